// File: rtl/jtframe_sat.sv
// Signed saturation from an IW-bit value to an OW-bit value, with an overflow flag.
// Purely combinational.
module jtframe_sat #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] i_din,
  output logic signed [OW-1:0] o_dout,
  output logic                 o_ovf
);

  generate
    if (IW > OW) begin : g_clamp
      logic [IW-OW:0] w_hi;
      assign w_hi = i_din[IW-1:OW-1];

      // The value fits only when every bit above the output sign bit matches it.
      always_comb begin
        o_dout = i_din[OW-1:0];
        o_ovf  = 1'b0;
        if ((w_hi != {(IW-OW+1){1'b0}}) && (w_hi != {(IW-OW+1){1'b1}})) begin
          o_ovf  = 1'b1;
          o_dout = i_din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
          o_ovf  = 1'b0;
        end
      end
    end else begin : g_pass
      assign o_dout = OW'(i_din);
      assign o_ovf  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/jtframe_tdm_acc.sv
// Accumulates SLOTS time-multiplexed signed samples into one saturated frame sum,
// strobing sample (and peak on clamp) for one clock when the frame completes.
module jtframe_tdm_acc #(
  parameter int W     = 14,
  parameter int SLOTS = 6,
  parameter int OW    = 16
) (
  input  logic                       rst_n,
  input  logic                       clk,
  input  logic                       clk_en,
  input  logic                       sync,
  input  logic [SLOTS-1:0]           en_mask,
  input  logic signed [W-1:0]        din,
  output logic [$clog2(SLOTS)-1:0]   slot,
  output logic signed [OW-1:0]       snd,
  output logic                       sample,
  output logic                       peak
);

  localparam int SW = $clog2(SLOTS);
  localparam int AW = W + SW;
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  logic [SW-1:0]        r_slot;
  logic signed [AW-1:0] r_acc;
  logic signed [OW-1:0] r_snd;
  logic                 r_sample;
  logic                 r_peak;

  logic [SW-1:0]        w_idx;
  logic signed [AW-1:0] w_m;
  logic signed [AW-1:0] w_total;
  logic signed [OW-1:0] w_sat;
  logic                 w_ovf;

  // A sync cycle is always treated as slot 0, including its mask bit.
  assign w_idx   = sync ? {SW{1'b0}} : r_slot;
  assign w_m     = en_mask[w_idx] ? AW'(din) : {AW{1'b0}};
  assign w_total = r_acc + w_m;

  jtframe_sat #(
    .IW (AW),
    .OW (OW)
  ) u_sat (
    .i_din  (w_total),
    .o_dout (w_sat),
    .o_ovf  (w_ovf)
  );

  // Slot counter, accumulator and frame output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= {SW{1'b0}};
      r_acc    <= {AW{1'b0}};
      r_snd    <= {OW{1'b0}};
      r_sample <= 1'b0;
      r_peak   <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_peak   <= 1'b0;
      if (clk_en) begin
        if (sync) begin
          r_acc  <= w_m;
          r_slot <= SW'(1);
        end else if (r_slot == {SW{1'b0}}) begin
          r_acc  <= w_m;
          r_slot <= SW'(1);
        end else if (r_slot == LAST) begin
          r_acc    <= {AW{1'b0}};
          r_slot   <= {SW{1'b0}};
          r_snd    <= w_sat;
          r_sample <= 1'b1;
          r_peak   <= w_ovf;
        end else begin
          r_acc  <= w_total;
          r_slot <= r_slot + SW'(1);
        end
      end
    end
  end

  assign slot   = r_slot;
  assign snd    = r_snd;
  assign sample = r_sample;
  assign peak   = r_peak;

endmodule

// File: tb/tb_jtframe_tdm_acc.sv
// Directed bench for jtframe_tdm_acc with W=14, SLOTS=6, OW=16.
module tb_jtframe_tdm_acc;

  logic               rst_n;
  logic               clk;
  logic               clk_en;
  logic               sync;
  logic [5:0]         en_mask;
  logic signed [13:0] din;
  logic [2:0]         slot;
  logic signed [15:0] snd;
  logic               sample;
  logic               peak;

  int errors = 0;
  int checks = 0;
  int pulses;

  jtframe_tdm_acc #(.W(14), .SLOTS(6), .OW(16)) dut (
    .rst_n   (rst_n),
    .clk     (clk),
    .clk_en  (clk_en),
    .sync    (sync),
    .en_mask (en_mask),
    .din     (din),
    .slot    (slot),
    .snd     (snd),
    .sample  (sample),
    .peak    (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic sy, input int d);
    clk_en = en;
    sync   = sy;
    din    = 14'(d);
    @(posedge clk);
    #1;
    if (sample === 1'b1) pulses++;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; sync = 1'b0; en_mask = 6'h3F; din = 14'sd0;
    pulses = 0;
    #23;
    chk("rst_snd", $signed(snd), 32'sd0);
    chk("rst_sample", {31'd0, sample}, 32'sd0);
    chk("rst_peak", {31'd0, peak}, 32'sd0);
    chk("rst_slot", {29'd0, slot}, 32'sd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 0);

    // Plain sum
    cyc(1'b1, 1'b0, 100); cyc(1'b1, 1'b0, 200); cyc(1'b1, 1'b0, -50);
    cyc(1'b1, 1'b0, 0);   cyc(1'b1, 1'b0, 1);
    chk("sum_presample", {31'd0, sample}, 32'sd0);
    cyc(1'b1, 1'b0, 2);
    chk("sum_snd", $signed(snd), 32'sd253);
    chk("sum_sample", {31'd0, sample}, 32'sd1);
    chk("sum_peak", {31'd0, peak}, 32'sd0);
    chk("sum_slot", {29'd0, slot}, 32'sd0);

    // Positive saturation
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8191);
    chk("psat_snd", $signed(snd), 32'sd32767);
    chk("psat_peak", {31'd0, peak}, 32'sd1);
    chk("psat_sample", {31'd0, sample}, 32'sd1);

    // Negative saturation
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, -8192);
    chk("nsat_snd", $signed(snd), -32'sd32768);
    chk("nsat_peak", {31'd0, peak}, 32'sd1);
    cyc(1'b0, 1'b0, 0);
    chk("strobe_drop", {31'd0, sample}, 32'sd0);
    chk("peak_drop", {31'd0, peak}, 32'sd0);

    // Mask
    en_mask = 6'b000011;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1000);
    chk("mask_snd", $signed(snd), 32'sd2000);
    chk("mask_peak", {31'd0, peak}, 32'sd0);
    en_mask = 6'h3F;

    // One enable in four clocks
    pulses = 0;
    cyc(1'b1, 1'b0, 100);  repeat (3) cyc(1'b0, 1'b0, 999);
    chk("slow_slot_hold", {29'd0, slot}, 32'sd1);
    chk("slow_snd_hold", $signed(snd), 32'sd2000);
    cyc(1'b1, 1'b0, 200);  repeat (3) cyc(1'b0, 1'b0, -999);
    cyc(1'b1, 1'b0, -50);  repeat (3) cyc(1'b0, 1'b1, 999);
    chk("slow_slot3", {29'd0, slot}, 32'sd3);
    cyc(1'b1, 1'b0, 0);    repeat (3) cyc(1'b0, 1'b0, 999);
    cyc(1'b1, 1'b0, 1);    repeat (3) cyc(1'b0, 1'b0, 999);
    cyc(1'b1, 1'b0, 2);
    chk("slow_snd", $signed(snd), 32'sd253);
    chk("slow_sample", {31'd0, sample}, 32'sd1);
    repeat (3) cyc(1'b0, 1'b0, 999);
    chk("slow_pulses", pulses, 32'sd1);
    chk("slow_snd_after", $signed(snd), 32'sd253);

    // Sync at slot 3
    pulses = 0;
    repeat (3) cyc(1'b1, 1'b0, 1);
    chk("sync3_pre_slot", {29'd0, slot}, 32'sd3);
    cyc(1'b1, 1'b1, 10);
    chk("sync3_slot", {29'd0, slot}, 32'sd1);
    chk("sync3_snd_hold", $signed(snd), 32'sd253);
    repeat (4) cyc(1'b1, 1'b0, 10);
    chk("sync3_nopulse", pulses, 32'sd0);
    cyc(1'b1, 1'b0, 10);
    chk("sync3_snd", $signed(snd), 32'sd60);
    chk("sync3_sample", {31'd0, sample}, 32'sd1);

    // Sync at slot 5
    pulses = 0;
    repeat (5) cyc(1'b1, 1'b0, 7);
    chk("sync5_pre_slot", {29'd0, slot}, 32'sd5);
    cyc(1'b1, 1'b1, 3);
    chk("sync5_sample", {31'd0, sample}, 32'sd0);
    chk("sync5_slot", {29'd0, slot}, 32'sd1);
    chk("sync5_snd_hold", $signed(snd), 32'sd60);
    repeat (5) cyc(1'b1, 1'b0, 3);
    chk("sync5_snd", $signed(snd), 32'sd18);
    chk("sync5_pulses", pulses, 32'sd1);

    // Reset mid-frame
    repeat (4) cyc(1'b1, 1'b0, 9);
    chk("rst_pre_slot", {29'd0, slot}, 32'sd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_snd", $signed(snd), 32'sd0);
    chk("rst2_sample", {31'd0, sample}, 32'sd0);
    chk("rst2_peak", {31'd0, peak}, 32'sd0);
    clk_en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 5);
    chk("rst_resume_snd", $signed(snd), 32'sd30);
    chk("rst_resume_sample", {31'd0, sample}, 32'sd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
